// File: rtl/game_pkg.sv
// Shared game constants and types for the cheese spawner.
// Holds the cheese y levels, cheese sprite width, the spawner state type
// and the Galois LFSR step shared by the spawner's random source.
package game_pkg;

    localparam int CHEESE_WIDTH = 32;

    // Screen rows a cheese may sit on; index 0 is the level used after reset.
    localparam logic [11:0] CHEESE_Y_LEVELS [4] = '{12'd200, 12'd350, 12'd500, 12'd650};

    typedef enum logic [1:0] {
        CS_SHOWN  = 2'd0,
        CS_HIDDEN = 2'd1,
        CS_DRAW   = 2'd2,
        CS_CHECK  = 2'd3
    } cheese_spawn_state_t;

    // One right-shift step of the Galois LFSR x^16+x^14+x^13+x^11.
    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

endpackage

// File: rtl/pos_if.sv
// Screen position bundle (12-bit x, 12-bit y) used for sprite positions.
interface pos_if;
    logic [11:0] x;
    logic [11:0] y;
    modport out (output x, output y);
    modport in  (input x, input y);
endinterface

// File: rtl/cheese_lfsr.sv
// 16-bit Galois LFSR (x^16+x^14+x^13+x^11) used as the cheese spawn source.
// rst reloads the seed asynchronously, load reloads it synchronously (game
// restart), step advances the sequence by one.
module cheese_lfsr
    import game_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        step,
    input  logic [15:0] seed,
    output logic [15:0] value
);

    // LFSR state: reload on either reset, otherwise advance when stepped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= seed;
        end else if (load) begin
            value <= seed;
        end else if (step) begin
            value <= lfsr_next(value);
        end else begin
            value <= value;
        end
    end

endmodule

// File: rtl/cheese_spawner.sv
// Cheese spawner: hides the cheese when taken, waits RESPAWN_DELAY cycles,
// then draws LFSR candidates until one is on screen and far enough from the
// previous spot (mirror fallback after MAX_TRIES rejects).
// Optional build macro: CHEESE_LFSR_FREERUN_EN -- LFSR runs every cycle so
// player timing perturbs the spawn sequence; undefined, it only steps in DRAW.
module cheese_spawner
    import game_pkg::*;
#(
    parameter int          X_MIN         = 32,
    parameter int          X_MAX         = 960,
    parameter int          X_INIT        = 512,
    parameter int          MIN_DIST      = 128,
    parameter int          RESPAWN_DELAY = 65_000_000,
    parameter int          MAX_TRIES     = 16,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
)
(
    input  logic clk,
    input  logic rst,
    input  logic reset,
    input  logic is_cheese_taken,
    pos_if.out   cheesepos,
    output logic cheese_visible,
    output logic cheese_spawned
);

    localparam int CNT_W = (RESPAWN_DELAY > 1) ? $clog2(RESPAWN_DELAY) : 1;
    localparam int TRY_W = $clog2(MAX_TRIES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RESPAWN_DELAY - 1);
    localparam logic [TRY_W-1:0] TRY_LAST = TRY_W'(MAX_TRIES);

    logic                rst_meta_r;
    logic                rst_sync_r;
    cheese_spawn_state_t state_r;
    logic [CNT_W-1:0]    delay_cnt_r;
    logic [TRY_W-1:0]    tries_r;
    logic [11:0]         pos_x_r;
    logic [11:0]         pos_y_r;
    logic [15:0]         lfsr_value_s;
    logic                lfsr_step_s;
    logic                unused_lfsr_bits_s;
    logic [11:0]         cand_x_s;
    logic [1:0]          cand_lvl_s;
    logic signed [12:0]  diff_s;
    logic [12:0]         abs_diff_s;
    logic                accept_s;
    logic [11:0]         fallback_x_s;

    // Reset stretcher: asserts with rst immediately, releases on a clk edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rst_meta_r <= 1'b1;
            rst_sync_r <= 1'b1;
        end else begin
            rst_meta_r <= 1'b0;
            rst_sync_r <= rst_meta_r;
        end
    end

`ifdef CHEESE_LFSR_FREERUN_EN
    assign lfsr_step_s = 1'b1;
`else
    assign lfsr_step_s = (state_r == CS_DRAW);
`endif

    cheese_lfsr u_lfsr (
        .clk   (clk),
        .rst   (rst_sync_r),
        .load  (reset),
        .step  (lfsr_step_s),
        .seed  (LFSR_SEED),
        .value (lfsr_value_s)
    );

    assign unused_lfsr_bits_s = ^lfsr_value_s[15:12];

    // Candidate evaluation against the on-screen range and the previous x.
    always_comb begin
        cand_x_s     = {2'b00, lfsr_value_s[9:0]};
        cand_lvl_s   = lfsr_value_s[11:10];
        diff_s       = $signed({1'b0, cand_x_s}) - $signed({1'b0, pos_x_r});
        abs_diff_s   = diff_s[12] ? $unsigned(-diff_s) : $unsigned(diff_s);
        accept_s     = (cand_x_s >= 12'(X_MIN)) && (cand_x_s <= 12'(X_MAX)) &&
                       (abs_diff_s >= 13'(MIN_DIST));
        fallback_x_s = 12'(X_MIN + X_MAX) - pos_x_r;
    end

    // Spawner FSM with registered position, visibility and spawn pulse.
    always_ff @(posedge clk or posedge rst_sync_r) begin
        if (rst_sync_r) begin
            state_r        <= CS_SHOWN;
            delay_cnt_r    <= '0;
            tries_r        <= '0;
            pos_x_r        <= 12'(X_INIT);
            pos_y_r        <= CHEESE_Y_LEVELS[0];
            cheese_visible <= 1'b1;
            cheese_spawned <= 1'b0;
        end else if (reset) begin
            state_r        <= CS_SHOWN;
            delay_cnt_r    <= '0;
            tries_r        <= '0;
            pos_x_r        <= 12'(X_INIT);
            pos_y_r        <= CHEESE_Y_LEVELS[0];
            cheese_visible <= 1'b1;
            cheese_spawned <= 1'b0;
        end else begin
            cheese_spawned <= 1'b0;
            case (state_r)
                CS_SHOWN: begin
                    if (is_cheese_taken) begin
                        state_r        <= CS_HIDDEN;
                        delay_cnt_r    <= '0;
                        tries_r        <= '0;
                        cheese_visible <= 1'b0;
                    end
                end
                CS_HIDDEN: begin
                    if (delay_cnt_r == CNT_LAST) begin
                        state_r     <= CS_DRAW;
                        delay_cnt_r <= '0;
                    end else begin
                        delay_cnt_r <= delay_cnt_r + CNT_W'(1);
                    end
                end
                CS_DRAW: begin
                    tries_r <= tries_r + TRY_W'(1);
                    state_r <= CS_CHECK;
                end
                CS_CHECK: begin
                    if (accept_s) begin
                        pos_x_r        <= cand_x_s;
                        pos_y_r        <= CHEESE_Y_LEVELS[cand_lvl_s];
                        cheese_spawned <= 1'b1;
                        cheese_visible <= 1'b1;
                        tries_r        <= '0;
                        state_r        <= CS_SHOWN;
                    end else if (tries_r >= TRY_LAST) begin
                        // Mirror around screen centre; keep the current row.
                        pos_x_r        <= fallback_x_s;
                        cheese_spawned <= 1'b1;
                        cheese_visible <= 1'b1;
                        tries_r        <= '0;
                        state_r        <= CS_SHOWN;
                    end else begin
                        state_r <= CS_DRAW;
                    end
                end
                default: begin
                    state_r        <= CS_SHOWN;
                    cheese_visible <= 1'b1;
                end
            endcase
        end
    end

    assign cheesepos.x = pos_x_r;
    assign cheesepos.y = pos_y_r;

endmodule

// File: tb/tb_cheese_spawner.sv
// Self-checking bench for cheese_spawner (RESPAWN_DELAY=100, deterministic LFSR).
module tb_cheese_spawner;
    import game_pkg::*;

    localparam int D = 100;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, reset, taken, vis, spawned;
    logic taken_fb, vis_fb, spawned_fb;

    pos_if pos();
    pos_if pos_fb();

    cheese_spawner #(.RESPAWN_DELAY(D)) dut (
        .clk(clk), .rst(rst), .reset(reset), .is_cheese_taken(taken),
        .cheesepos(pos), .cheese_visible(vis), .cheese_spawned(spawned)
    );

    cheese_spawner #(.RESPAWN_DELAY(D), .MIN_DIST(2000)) dut_fb (
        .clk(clk), .rst(rst), .reset(reset), .is_cheese_taken(taken_fb),
        .cheesepos(pos_fb), .cheese_visible(vis_fb), .cheese_spawned(spawned_fb)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model state: LFSR value and current cheese position.
    logic [15:0] m_lfsr;
    logic [11:0] m_x, m_y;
    int          m_tries;

    logic [11:0] seq_x [20];
    logic [11:0] seq_y [20];

    // Polynomial x^16+x^14+x^13+x^11 in right-shift Galois form.
    function automatic logic [15:0] ref_step(input logic [15:0] v);
        logic [15:0] mask;
        mask = 16'((1 << 15) | (1 << 13) | (1 << 12) | (1 << 10));
        return v[0] ? ((v >> 1) ^ mask) : (v >> 1);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_lfsr = 16'hACE1;
        m_x    = 12'd512;
        m_y    = CHEESE_Y_LEVELS[0];
    endtask

    // Draw candidates the way the game rules describe and pick the new spot.
    task automatic model_spawn();
        int          tries;
        int          d;
        bit          ok;
        logic [11:0] cx;
        logic [1:0]  lvl;
        tries = 0;
        ok = 1'b0;
        while (!ok && tries < 16) begin
            m_lfsr = ref_step(m_lfsr);
            tries++;
            cx  = {2'b00, m_lfsr[9:0]};
            lvl = m_lfsr[11:10];
            d   = int'(cx) - int'(m_x);
            if (d < 0) d = -d;
            if (cx >= 12'd32 && cx <= 12'd960 && d >= 128) begin
                m_x = cx;
                m_y = CHEESE_Y_LEVELS[lvl];
                ok  = 1'b1;
            end
        end
        if (!ok) m_x = 12'(32 + 960 - int'(m_x));
        m_tries = tries;
    endtask

    // One take on the main DUT, checked against the model; noisy adds stray takes.
    task automatic do_take_main(input bit noisy, input string tag,
                                output logic [11:0] got_x, output logic [11:0] got_y);
        int lat;
        int exp_lat;
        bit seen_vis;
        model_spawn();
        exp_lat  = D + 2 * m_tries;
        lat      = 0;
        seen_vis = 1'b0;
        taken = 1'b1;
        tick();
        taken = 1'b0;
        vectors++;
        if (vis !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_hide: visible=%b want 0", tag, vis);
        end
        for (int n = 1; n <= 400; n++) begin
            taken = (noisy && n < D - 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            tick();
            if (spawned === 1'b1) begin
                lat = n;
                break;
            end
            if (vis !== 1'b0) seen_vis = 1'b1;
        end
        taken = 1'b0;
        got_x = pos.x;
        got_y = pos.y;
        vectors++;
        if (seen_vis) begin
            miscompares++;
            $display("FAIL %s_hidden_vis: cheese visible while hidden", tag);
        end
        vectors++;
        if (lat != exp_lat) begin
            miscompares++;
            $display("FAIL %s_latency: %0d cycles want %0d", tag, lat, exp_lat);
        end
        vectors++;
        if (pos.x !== m_x || pos.y !== m_y) begin
            miscompares++;
            $display("FAIL %s_pos: (%0d,%0d) want (%0d,%0d)", tag, pos.x, pos.y, m_x, m_y);
        end
        vectors++;
        if (vis !== 1'b1) begin
            miscompares++;
            $display("FAIL %s_show: visible=%b want 1", tag, vis);
        end
        tick();
        vectors++;
        if (spawned !== 1'b0 || vis !== 1'b1) begin
            miscompares++;
            $display("FAIL %s_pulse: spawned=%b visible=%b want 0/1", tag, spawned, vis);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; reset = 1'b0; taken = 1'b0; taken_fb = 1'b0;
        #2;
        vectors++;
        if (pos.x !== 12'd512 || pos.y !== CHEESE_Y_LEVELS[0] || vis !== 1'b1 || spawned !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_async: x=%0d y=%0d vis=%b sp=%b want 512/%0d/1/0",
                     pos.x, pos.y, vis, spawned, CHEESE_Y_LEVELS[0]);
        end
        repeat (3) tick();
        rst = 1'b0;
        repeat (3) tick();
        vectors++;
        if (pos.x !== 12'd512 || pos.y !== CHEESE_Y_LEVELS[0] || vis !== 1'b1 || spawned !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_idle: x=%0d y=%0d vis=%b sp=%b want 512/%0d/1/0",
                     pos.x, pos.y, vis, spawned, CHEESE_Y_LEVELS[0]);
        end
        vectors++;
        if (pos_fb.x !== 12'd512 || vis_fb !== 1'b1 || spawned_fb !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_fb: x=%0d vis=%b sp=%b want 512/1/0", pos_fb.x, vis_fb, spawned_fb);
        end
        model_reset();
    endtask

    task automatic test_take_basic();
        logic [11:0] x, y;
        int d;
        do_take_main(1'b0, "basic", x, y);
        d = int'(x) - 512;
        if (d < 0) d = -d;
        vectors++;
        if (x < 12'd32 || x > 12'd960 || d < 128) begin
            miscompares++;
            $display("FAIL basic_rules: x=%0d want in [32,960] and >=128 from 512", x);
        end
    endtask

    task automatic test_ignore_taken();
        logic [11:0] x, y;
        do_take_main(1'b1, "noisy", x, y);
    endtask

    task automatic test_fallback();
        logic [11:0] exp_x;
        int lat;
        exp_x = 12'd512;
        for (int k = 0; k < 2; k++) begin
            exp_x = 12'(992 - int'(exp_x));
            lat = 0;
            taken_fb = 1'b1;
            tick();
            taken_fb = 1'b0;
            for (int n = 1; n <= 400; n++) begin
                tick();
                if (spawned_fb === 1'b1) begin
                    lat = n;
                    break;
                end
            end
            vectors++;
            if (lat < D + 32 || lat > D + 33) begin
                miscompares++;
                $display("FAIL fallback_latency%0d: %0d cycles want %0d..%0d", k, lat, D + 32, D + 33);
            end
            vectors++;
            if (pos_fb.x !== exp_x || pos_fb.y !== CHEESE_Y_LEVELS[0]) begin
                miscompares++;
                $display("FAIL fallback_pos%0d: (%0d,%0d) want (%0d,%0d)", k, pos_fb.x, pos_fb.y,
                         exp_x, CHEESE_Y_LEVELS[0]);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_hidden();
        bit bad;
        taken = 1'b1;
        tick();
        taken = 1'b0;
        repeat (50) tick();
        reset = 1'b1;
        taken = 1'b1;
        tick();
        reset = 1'b0;
        taken = 1'b0;
        vectors++;
        if (pos.x !== 12'd512 || pos.y !== CHEESE_Y_LEVELS[0] || vis !== 1'b1 || spawned !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_state: x=%0d y=%0d vis=%b sp=%b want 512/%0d/1/0",
                     pos.x, pos.y, vis, spawned, CHEESE_Y_LEVELS[0]);
        end
        bad = 1'b0;
        for (int n = 0; n < 2 * D; n++) begin
            tick();
            if (spawned !== 1'b0 || vis !== 1'b1) bad = 1'b1;
        end
        vectors++;
        if (bad) begin
            miscompares++;
            $display("FAIL midreset_quiet: spawn or hide after discarded respawn");
        end
        model_reset();
    endtask

    task automatic test_sequence();
        logic [11:0] x, y;
        for (int run = 0; run < 2; run++) begin
            reset = 1'b1;
            tick();
            reset = 1'b0;
            model_reset();
            for (int i = 0; i < 20; i++) begin
                do_take_main(1'b0, $sformatf("seq%0d_%0d", run, i), x, y);
                if (run == 0) begin
                    seq_x[i] = x;
                    seq_y[i] = y;
                end else begin
                    vectors++;
                    if (x !== seq_x[i] || y !== seq_y[i]) begin
                        miscompares++;
                        $display("FAIL repeat_%0d: (%0d,%0d) want (%0d,%0d)", i, x, y, seq_x[i], seq_y[i]);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_take_basic();
        test_ignore_taken();
        test_fallback();
        test_reset_mid_hidden();
        test_sequence();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
